// File: rtl/fsm_merge_pkg.sv
// Shared types for the N-channel output-merge FSM.
package fsm_merge_pkg;

    localparam int DEF_IDX_W = 10;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT_DATA,
        S_PUSH,
        S_PUSH_INC,
        S_OF_FULL
    } state_t;

endpackage

// File: rtl/merge_pick_lowest.sv
// Priority encoder: reports whether any request is set and the lowest set index.
module merge_pick_lowest #(
    parameter  int NUM_CH = 2,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic              o_valid,
    output logic [SEL_W-1:0]  o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Walking downwards lets the lowest set bit win.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/fsm_merge_n.sv
// Merges NUM_CH encoder channels into one output FIFO in ascending field-index order,
// one byte per grant, with FIFO-full stall, synchronous restart and a sticky conflict flag.
module fsm_merge_n
    import fsm_merge_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int IDX_W  = DEF_IDX_W,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    input  logic [IDX_W-1:0]        start_index,
    input  logic                    out_fifo_full,
    input  logic [NUM_CH*IDX_W-1:0] ch_in_index_q,
    input  logic [NUM_CH*IDX_W-1:0] ch_out_index_q,
    input  logic [NUM_CH-1:0]       ch_data_valid,
    input  logic [NUM_CH-1:0]       ch_encoding,
    output logic                    out_fifo_clr,
    output logic                    out_fifo_push,
    output logic [SEL_W-1:0]        out_sel,
    output logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       ch_data_accepted,
    output logic [IDX_W-1:0]        out_index,
    output logic [IDX_W-1:0]        out_index_plus1,
    output logic                    idx_conflict,
    output state_t                  dbg_state
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_cur_idx;
    logic [IDX_W-1:0]    r_idx_p1;
    logic [SEL_W-1:0]    r_sel;
    logic                r_clr;
    logic                r_push;
    logic [NUM_CH-1:0]   r_acc;
    logic                r_conflict;

    logic [IDX_W-1:0]    w_cur_p1;
    logic [NUM_CH-1:0]   w_eq_cur;
    logic [NUM_CH-1:0]   w_eq_next;
    logic [NUM_CH-1:0]   w_enc_hit;
    logic [NUM_CH-1:0]   w_next_ok;
    logic                w_blk;
    logic                w_multi_cur;
    logic                w_cur_any;
    logic                w_nxt_any;
    logic [SEL_W-1:0]    w_cur_sel;
    logic [SEL_W-1:0]    w_nxt_sel;

    assign w_cur_p1 = r_cur_idx + IDX_W'(1);

    always_comb begin
        w_eq_cur  = '0;
        w_eq_next = '0;
        w_enc_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_eq_cur[i]  = ch_data_valid[i] && (ch_out_index_q[i*IDX_W +: IDX_W] == r_cur_idx);
            w_eq_next[i] = ch_data_valid[i] && (ch_out_index_q[i*IDX_W +: IDX_W] == w_cur_p1);
            w_enc_hit[i] = ch_encoding[i] && (ch_in_index_q[i*IDX_W +: IDX_W] == r_cur_idx);
        end
    end

    // The next field may only start once nothing can still produce bytes for the current one.
    assign w_blk       = |(w_enc_hit | w_eq_cur);
    assign w_next_ok   = w_eq_next & {NUM_CH{!w_blk}};
    assign w_multi_cur = (w_eq_cur & (w_eq_cur - NUM_CH'(1))) != '0;

    merge_pick_lowest #(.NUM_CH(NUM_CH)) u_pick_cur (
        .i_req   (w_eq_cur),
        .o_valid (w_cur_any),
        .o_idx   (w_cur_sel)
    );

    merge_pick_lowest #(.NUM_CH(NUM_CH)) u_pick_next (
        .i_req   (w_next_ok),
        .o_valid (w_nxt_any),
        .o_idx   (w_nxt_sel)
    );

    // Push/accept contract: out_fifo_push and the one-hot ch_data_accepted are high together
    // for exactly one cycle per byte; the channel pops its head on that cycle and no other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_INIT;
            r_cur_idx  <= '0;
            r_idx_p1   <= '0;
            r_sel      <= '0;
            r_clr      <= 1'b1;
            r_push     <= 1'b0;
            r_acc      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_push <= 1'b0;
            r_acc  <= '0;
            if (restart) begin
                r_state    <= S_INIT;
                r_clr      <= 1'b1;
                r_cur_idx  <= start_index;
                r_idx_p1   <= start_index + IDX_W'(1);
                r_conflict <= 1'b0;
            end else begin
                case (r_state)
                    S_INIT: begin
                        r_cur_idx  <= start_index;
                        r_idx_p1   <= start_index + IDX_W'(1);
                        r_conflict <= 1'b0;
                        r_state    <= S_WAIT_DATA;
                    end
                    S_WAIT_DATA, S_OF_FULL: begin
                        if (w_multi_cur) begin
                            r_conflict <= 1'b1;
                        end
                        if (out_fifo_full) begin
                            r_state <= S_OF_FULL;
                        end else if (w_cur_any) begin
                            r_state <= S_PUSH;
                            r_sel   <= w_cur_sel;
                            r_push  <= 1'b1;
                            r_acc   <= NUM_CH'(1) << w_cur_sel;
                        end else if (w_nxt_any) begin
                            r_state <= S_PUSH_INC;
                            r_sel   <= w_nxt_sel;
                            r_push  <= 1'b1;
                            r_acc   <= NUM_CH'(1) << w_nxt_sel;
                        end else begin
                            r_state <= S_WAIT_DATA;
                        end
                    end
                    S_PUSH: begin
                        r_state <= out_fifo_full ? S_OF_FULL : S_WAIT_DATA;
                    end
                    S_PUSH_INC: begin
                        r_cur_idx <= w_cur_p1;
                        r_idx_p1  <= w_cur_p1 + IDX_W'(1);
                        r_state   <= out_fifo_full ? S_OF_FULL : S_WAIT_DATA;
                    end
                    default: begin
                        r_state <= S_INIT;
                    end
                endcase
            end
        end
    end

    assign out_fifo_clr     = r_clr;
    assign out_fifo_push    = r_push;
    assign out_sel          = r_sel;
    assign ch_data_accepted = r_acc;
    assign ch_enable        = {NUM_CH{(r_state != S_INIT) && !out_fifo_full}};
    assign out_index        = r_cur_idx;
    assign out_index_plus1  = r_idx_p1;
    assign idx_conflict     = r_conflict;
    assign dbg_state        = r_state;

endmodule
